// File: rtl/sliding_window.sv
// sliding_window: serial sample stream -> WINDOW_SIZE-wide parallel windows
// emitted every STRIDE accepted samples, valid/ready on both sides.
// Optional build macro SLIDING_WINDOW_ZERO_PAD_EN enables causal zero padding:
// every sequence starts from an all-zero history, so the first sample of a
// sequence already completes a window [0,..,0,x0].

// One window tap: loads its neighbour (or zero on a new padded sequence).
module sliding_window_tap #(
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  shift,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);
    // Tap register, advances only on an accepted sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     q <= '0;
        else if (shift) q <= clr ? '0 : d;
    end
endmodule

module sliding_window #(
    parameter int DATA_WIDTH  = 12,
    parameter int WINDOW_SIZE = 3,
    parameter int STRIDE      = 1
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    output logic                                    win_ready_in,
    input  logic                                    win_valid_in,
    input  logic [DATA_WIDTH-1:0]                   win_data_in,
    input  logic                                    win_last_in,
    input  logic                                    win_ready_out,
    output logic                                    win_valid_out,
    output logic [0:WINDOW_SIZE-1][DATA_WIDTH-1:0]  win_data_out
);
    localparam int FW = $clog2(WINDOW_SIZE + 1);
    localparam int SW = $clog2(STRIDE + 1);

`ifdef SLIDING_WINDOW_ZERO_PAD_EN
    localparam logic [FW-1:0] FILL_START = FW'(WINDOW_SIZE - 1);
`else
    localparam logic [FW-1:0] FILL_START = '0;
`endif

    logic [FW-1:0] fill_cnt;
    logic [SW-1:0] stride_cnt;
    logic          accept;
    logic          full_next;
    logic          emit;
    logic          seq_clr;

    assign win_ready_in = ~win_valid_out | win_ready_out;
    assign accept       = win_valid_in & win_ready_in;
    assign full_next    = (int'(fill_cnt) + 1) >= WINDOW_SIZE;
    assign emit         = accept & full_next & (stride_cnt == '0);

`ifdef SLIDING_WINDOW_ZERO_PAD_EN
    // The history clear after a last sample is deferred to the first sample
    // of the next sequence, so the window emitted by the last sample survives
    // until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      seq_clr <= 1'b1;
        else if (accept) seq_clr <= win_last_in;
    end
`else
    assign seq_clr = 1'b0;
`endif

    // Shift register: [0] oldest, [WINDOW_SIZE-1] newest, drives output directly
    for (genvar i = 0; i < WINDOW_SIZE; i++) begin : g_tap
        if (i == WINDOW_SIZE - 1) begin : g_head
            sliding_window_tap #(.DATA_WIDTH(DATA_WIDTH)) u_tap (
                .clk   (clk),
                .rst_n (rst_n),
                .shift (accept),
                .clr   (1'b0),
                .d     (win_data_in),
                .q     (win_data_out[i])
            );
        end else begin : g_body
            sliding_window_tap #(.DATA_WIDTH(DATA_WIDTH)) u_tap (
                .clk   (clk),
                .rst_n (rst_n),
                .shift (accept),
                .clr   (seq_clr),
                .d     (win_data_out[i+1]),
                .q     (win_data_out[i])
            );
        end
    end

    // Fill count: saturating per-sequence sample count, restarts after last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt <= FILL_START;
        end else if (accept) begin
            if (win_last_in)
                fill_cnt <= FILL_START;
            else if (fill_cnt < FW'(WINDOW_SIZE))
                fill_cnt <= fill_cnt + FW'(1);
        end
    end

    // Stride phase: only advances once the window is full; 0 means emit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stride_cnt <= '0;
        end else if (accept) begin
            if (win_last_in)
                stride_cnt <= '0;
            else if (full_next)
                stride_cnt <= (stride_cnt == SW'(STRIDE - 1)) ? '0 : stride_cnt + SW'(1);
        end
    end

    // Output valid: emit wins over a take in the same cycle (no bubble)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             win_valid_out <= 1'b0;
        else if (emit)          win_valid_out <= 1'b1;
        else if (win_ready_out) win_valid_out <= 1'b0;
    end
endmodule
